// File: rtl/quad_decoder.sv
// Quadrature decoder: turns debounced encoder A/B phases into detent step strobes,
// direction, a wrapping position count and a saturating illegal-transition count.
module quad_decoder #(
    parameter int W      = 8,
    parameter int DETENT = 4,
    parameter int ERR_W  = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             a,
    input  logic             b,
    input  logic             clr,
    output logic             inc,
    output logic             dec,
    output logic             dir,
    output logic [W-1:0]     pos,
    output logic             err,
    output logic [ERR_W-1:0] err_cnt
);

    // move code | meaning
    // MV_HOLD   | phase unchanged
    // MV_FWD    | one forward quarter-step
    // MV_ILL    | both phases changed in one cycle
    // MV_REV    | one reverse quarter-step
    localparam logic [1:0] MV_HOLD = 2'd0;
    localparam logic [1:0] MV_FWD  = 2'd1;
    localparam logic [1:0] MV_ILL  = 2'd2;
    localparam logic [1:0] MV_REV  = 2'd3;

    localparam int SW = 4;
    localparam logic signed [SW-1:0] SUB_TOP = SW'(DETENT - 1);
    localparam logic signed [SW-1:0] SUB_BOT = SW'(1 - DETENT);

    logic [1:0]              prev_q, prev_d;
    logic                    loaded_q, loaded_d;
    logic signed [SW-1:0]    sub_q, sub_d;
    logic [W-1:0]            pos_q, pos_d;
    logic                    dir_q, dir_d;
    logic                    inc_q, inc_d;
    logic                    dec_q, dec_d;
    logic                    err_q, err_d;
    logic [ERR_W-1:0]        err_cnt_q, err_cnt_d;

    logic [1:0] idx_s, idx_p, mv;

    // Gray phase mapped to a linear 0..3 index so the modulo-4 difference is the move code.
    assign idx_s = {a, a ^ b};
    assign idx_p = {prev_q[1], prev_q[1] ^ prev_q[0]};
    assign mv    = idx_s - idx_p;

    always_comb begin
        prev_d    = {a, b};
        loaded_d  = 1'b1;
        sub_d     = sub_q;
        pos_d     = pos_q;
        dir_d     = dir_q;
        inc_d     = 1'b0;
        dec_d     = 1'b0;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;

        if (loaded_q) begin
            case (mv)
                MV_FWD: begin
                    if (sub_q == SUB_TOP) begin
                        sub_d = '0;
                        pos_d = pos_q + W'(1);
                        inc_d = 1'b1;
                        dir_d = 1'b1;
                    end else begin
                        sub_d = sub_q + SW'(1);
                    end
                end
                MV_REV: begin
                    if (sub_q == SUB_BOT) begin
                        sub_d = '0;
                        pos_d = pos_q - W'(1);
                        dec_d = 1'b1;
                        dir_d = 1'b0;
                    end else begin
                        sub_d = sub_q - SW'(1);
                    end
                end
                MV_ILL: begin
                    err_d = 1'b1;
                    sub_d = '0;
                    if (err_cnt_q != '1) begin
                        err_cnt_d = err_cnt_q + ERR_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end

        // A clear wins over a completing step; no step is reported so dir holds.
        if (clr) begin
            pos_d = '0;
            sub_d = '0;
            inc_d = 1'b0;
            dec_d = 1'b0;
            dir_d = dir_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_q    <= 2'b00;
            loaded_q  <= 1'b0;
            sub_q     <= '0;
            pos_q     <= '0;
            dir_q     <= 1'b0;
            inc_q     <= 1'b0;
            dec_q     <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            prev_q    <= prev_d;
            loaded_q  <= loaded_d;
            sub_q     <= sub_d;
            pos_q     <= pos_d;
            dir_q     <= dir_d;
            inc_q     <= inc_d;
            dec_q     <= dec_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign inc     = inc_q;
    assign dec     = dec_q;
    assign dir     = dir_q;
    assign pos     = pos_q;
    assign err     = err_q;
    assign err_cnt = err_cnt_q;

endmodule

// File: tb/tb_quad_decoder.sv
// Scoreboard bench for quad_decoder (W=8, DETENT=4, ERR_W=8): expected outputs are
// pushed when each phase is driven and popped after the sampling edge.
module tb_quad_decoder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       a = 1'b0, b = 1'b0, clr = 1'b0;
    logic       inc, dec, dir, err;
    logic [7:0] pos, err_cnt;

    int total = 0;
    int bad = 0;

    quad_decoder #(.W(8), .DETENT(4), .ERR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .a(a), .b(b), .clr(clr),
        .inc(inc), .dec(dec), .dir(dir), .pos(pos), .err(err), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // {inc, dec, err, dir, pos[7:0], err_cnt[7:0]}
    logic [19:0] sbq [$];
    logic [19:0] exp_v, got_v;

    logic [1:0] fwd_next [4];
    logic [1:0] fseq [4];
    logic [1:0] rseq [4];
    logic [1:0] mprev;
    int         msub;
    logic [7:0] mpos;
    logic       mdir;
    int         merr;

    assign got_v = {inc, dec, err, dir, pos, err_cnt};

    task automatic drive(input logic [1:0] s, input logic nclr);
        logic e_inc, e_dec, e_err;
        int   step;
        @(negedge clk);
        {a, b} = s;
        clr    = nclr;
        e_inc = 1'b0; e_dec = 1'b0; e_err = 1'b0; step = 0;
        if (s == mprev) begin
        end else if (s == fwd_next[mprev]) begin
            msub = msub + 1;
            if (msub == 4) begin msub = 0; step = 1; end
        end else if (mprev == fwd_next[s]) begin
            msub = msub - 1;
            if (msub == -4) begin msub = 0; step = -1; end
        end else begin
            e_err = 1'b1;
            msub  = 0;
            if (merr < 255) merr = merr + 1;
        end
        if (nclr) begin
            mpos = 8'd0;
            msub = 0;
        end else if (step == 1) begin
            mpos = mpos + 8'd1; e_inc = 1'b1; mdir = 1'b1;
        end else if (step == -1) begin
            mpos = mpos - 8'd1; e_dec = 1'b1; mdir = 1'b0;
        end
        mprev = s;
        sbq.push_back({e_inc, e_dec, e_err, mdir, mpos, merr[7:0]});
    endtask

    task automatic do_reset(input logic [1:0] s);
        @(negedge clk);
        rst_n = 1'b0;
        {a, b} = s;
        clr = 1'b0;
        mprev = s; msub = 0; mpos = 8'd0; mdir = 1'b0; merr = 0;
        sbq.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; {a, b} = 2'b11; clr = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (got_v !== 20'h0) begin
            bad++; $display("FAIL reset_state got=%h exp=%h", got_v, 20'h0);
        end
        mprev = 2'b11; msub = 0; mpos = 8'd0; mdir = 1'b0; merr = 0;
        sbq.delete();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            drive(2'b11, 1'b0);
            @(posedge clk); #1;
            exp_v = sbq.pop_front();
            total++;
            if (got_v !== exp_v) begin
                bad++; $display("FAIL reset_hold11 got=%h exp=%h", got_v, exp_v);
            end
        end
        total++;
        if (err_cnt !== 8'd0 || pos !== 8'd0) begin
            bad++; $display("FAIL reset_load got pos=%h err_cnt=%h exp 00/00", pos, err_cnt);
        end
    endtask

    task automatic test_fwd_detent();
        int n_inc = 0, n_dec = 0;
        do_reset(2'b00);
        for (int i = 0; i < 12; i++) begin
            drive(fseq[i/3], 1'b0);
            @(posedge clk); #1;
            exp_v = sbq.pop_front();
            n_inc += int'(inc); n_dec += int'(dec);
            total++;
            if (got_v !== exp_v) begin
                bad++; $display("FAIL fwd_detent step=%0d got=%h exp=%h", i, got_v, exp_v);
            end
        end
        total++;
        if (n_inc != 1 || n_dec != 0 || pos !== 8'd1 || dir !== 1'b1) begin
            bad++; $display("FAIL fwd_summary got inc=%0d dec=%0d pos=%h dir=%b exp 1/0/01/1",
                            n_inc, n_dec, pos, dir);
        end
    endtask

    task automatic test_reverse();
        int n_dec = 0;
        do_reset(2'b00);
        for (int i = 0; i < 32; i++) begin
            drive(rseq[i%4], 1'b0);
            @(posedge clk); #1;
            exp_v = sbq.pop_front();
            n_dec += int'(dec);
            total++;
            if (got_v !== exp_v) begin
                bad++; $display("FAIL reverse step=%0d got=%h exp=%h", i, got_v, exp_v);
            end
        end
        total++;
        if (n_dec != 8 || pos !== 8'hF8 || dir !== 1'b0) begin
            bad++; $display("FAIL reverse_summary got dec=%0d pos=%h dir=%b exp 8/f8/0", n_dec, pos, dir);
        end
    endtask

    task automatic test_reversal();
        logic [1:0] seq [8];
        int n_strobe = 0;
        seq = '{2'b01, 2'b11, 2'b01, 2'b00, 2'b01, 2'b11, 2'b10, 2'b00};
        do_reset(2'b00);
        for (int i = 0; i < 8; i++) begin
            drive(seq[i], 1'b0);
            @(posedge clk); #1;
            exp_v = sbq.pop_front();
            if (i < 4) n_strobe += int'(inc) + int'(dec);
            total++;
            if (got_v !== exp_v) begin
                bad++; $display("FAIL reversal step=%0d got=%h exp=%h", i, got_v, exp_v);
            end
        end
        total++;
        if (n_strobe != 0 || pos !== 8'd1) begin
            bad++; $display("FAIL reversal_summary got strobes=%0d pos=%h exp 0/01", n_strobe, pos);
        end
    endtask

    task automatic test_illegal();
        do_reset(2'b00);
        for (int i = 0; i < 300; i++) begin
            drive((i % 2 == 0) ? 2'b11 : 2'b00, 1'b0);
            @(posedge clk); #1;
            exp_v = sbq.pop_front();
            total++;
            if (got_v !== exp_v) begin
                bad++; $display("FAIL illegal n=%0d got=%h exp=%h", i, got_v, exp_v);
            end
        end
        drive(2'b00, 1'b0);
        @(posedge clk); #1;
        exp_v = sbq.pop_front();
        total++;
        if (got_v !== exp_v || err_cnt !== 8'd255 || err !== 1'b0) begin
            bad++; $display("FAIL illegal_sat got=%h err_cnt=%h exp=%h err_cnt=ff", got_v, err_cnt, exp_v);
        end
    endtask

    task automatic test_wrap_clr();
        do_reset(2'b00);
        for (int i = 0; i < 512; i++) begin
            drive(fseq[i%4], 1'b0);
            @(posedge clk); #1;
            exp_v = sbq.pop_front();
            total++;
            if (got_v !== exp_v) begin
                bad++; $display("FAIL wrap step=%0d got=%h exp=%h", i, got_v, exp_v);
            end
            if (i == 507) begin
                total++;
                if (pos !== 8'd127) begin
                    bad++; $display("FAIL wrap_pre got pos=%h exp 7f", pos);
                end
            end
        end
        total++;
        if (pos !== 8'h80) begin
            bad++; $display("FAIL wrap_post got pos=%h exp 80", pos);
        end
        for (int i = 0; i < 5; i++) begin
            drive((i < 4) ? fseq[i] : 2'b11, (i >= 3));
            @(posedge clk); #1;
            exp_v = sbq.pop_front();
            total++;
            if (got_v !== exp_v) begin
                bad++; $display("FAIL clr step=%0d got=%h exp=%h", i, got_v, exp_v);
            end
            if (i == 3) begin
                total++;
                if (pos !== 8'd0 || inc !== 1'b0) begin
                    bad++; $display("FAIL clr_step got pos=%h inc=%b exp 00/0", pos, inc);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        do_reset(2'b00);
        for (int i = 0; i < 6; i++) begin
            drive((i < 4) ? fseq[i] : ((i == 4) ? 2'b11 : 2'b01), 1'b0);
            @(posedge clk); #1;
            exp_v = sbq.pop_front();
            total++;
            if (got_v !== exp_v) begin
                bad++; $display("FAIL b2b step=%0d got=%h exp=%h", i, got_v, exp_v);
            end
        end
        @(negedge clk); #1;
        rst_n = 1'b0;
        #1;
        total++;
        if (got_v !== 20'h0) begin
            bad++; $display("FAIL midreset got=%h exp=%h", got_v, 20'h0);
        end
        {a, b} = 2'b11;
        mprev = 2'b11; msub = 0; mpos = 8'd0; mdir = 1'b0; merr = 0;
        sbq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive((i < 3) ? 2'b11 : 2'b10, 1'b0);
            @(posedge clk); #1;
            exp_v = sbq.pop_front();
            total++;
            if (got_v !== exp_v) begin
                bad++; $display("FAIL midreset_reload step=%0d got=%h exp=%h", i, got_v, exp_v);
            end
        end
    endtask

    initial begin
        fwd_next[0] = 2'b01; fwd_next[1] = 2'b11; fwd_next[2] = 2'b00; fwd_next[3] = 2'b10;
        fseq[0] = 2'b01; fseq[1] = 2'b11; fseq[2] = 2'b10; fseq[3] = 2'b00;
        rseq[0] = 2'b10; rseq[1] = 2'b11; rseq[2] = 2'b01; rseq[3] = 2'b00;
        test_reset();
        test_fwd_detent();
        test_reverse();
        test_reversal();
        test_illegal();
        test_wrap_clr();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
